// File: rtl/cla_sub_pipe_32_pkg.sv
// Shared widths, flag indices and saturation limits for cla_sub_pipe_32.
// Also holds the Kogge-Stone prefix step used by the 16-bit CLA slice.
package cla_sub_pipe_32_pkg;

    localparam int N_16 = 16;
    localparam int N_32 = 2 * N_16;

    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 0;

    localparam logic [N_32-1:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [N_32-1:0] SAT_MIN = 32'h8000_0000;

    // Stage-1 to stage-2 bundle: low result, its carry, high operands.
    typedef struct packed {
        logic [N_16-1:0] dlo;
        logic            clo;
        logic [N_16-1:0] ahi;
        logic [N_16-1:0] bhi;
    } s1_t;

    // One prefix level: combine each (g,p) with the pair d bits below.
    function automatic logic [2*N_16-1:0] ks_step(
        input logic [N_16-1:0] g,
        input logic [N_16-1:0] p,
        input int              d
    );
        logic [N_16-1:0] gn;
        logic [N_16-1:0] pn;
        gn = g;
        pn = p;
        for (int i = 0; i < N_16; i++) begin
            if (i >= d) begin
                gn[i] = g[i] | (p[i] & g[i-d]);
                pn[i] = p[i] & p[i-d];
            end
        end
        return {gn, pn};
    endfunction

endpackage

// File: rtl/cla_sub_pipe_32_cla_sub_16.sv
// 16-bit parallel-prefix adder computing x + ~y + cin.
// Four Kogge-Stone levels produce every carry from the group terms.
module cla_sub_16
    import cla_sub_pipe_32_pkg::*;
(
    input  logic [N_16-1:0] x,
    input  logic [N_16-1:0] y,
    input  logic            cin,
    output logic [N_16-1:0] sum,
    output logic            cout
);

    logic [N_16-1:0] g0, p0;
    logic [N_16-1:0] g1, p1;
    logic [N_16-1:0] g2, p2;
    logic [N_16-1:0] g3, p3;
    logic [N_16-1:0] g4, p4;
    logic [N_16:0]   c;

    assign g0 = x & ~y;
    assign p0 = x ^ ~y;

    assign {g1, p1} = ks_step(g0, p0, 1);
    assign {g2, p2} = ks_step(g1, p1, 2);
    assign {g3, p3} = ks_step(g2, p2, 4);
    assign {g4, p4} = ks_step(g3, p3, 8);

    // Carry into bit i+1 is the group generate over [i:0] plus cin.
    assign c    = {g4 | (p4 & {N_16{cin}}), cin};
    assign sum  = p0 ^ c[N_16-1:0];
    assign cout = c[N_16];

endmodule

// File: rtl/cla_sub_pipe_32.sv
// Two-stage 32-bit subtractor D = A - B - BIN with valid/ready flow control.
// Optional macro CLA_SUB_SAT_EN enables signed saturation on overflow.
module cla_sub_pipe_32
    import cla_sub_pipe_32_pkg::*;
(
    input  logic            CLK,
    input  logic            RST,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [N_32-1:0] OPA,
    input  logic [N_32-1:0] OPB,
    input  logic            BIN,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [N_32-1:0] DIFF,
    output logic            BOUT,
    output logic [2:0]      FLAGS
);

    logic            s1_valid;
    s1_t             s1_q;
    s1_t             s1_d;
    logic            s1_ready;
    logic            s2_ready;
    logic            accept;

    logic [N_16-1:0] lo_sum;
    logic            lo_cout;
    logic [N_16-1:0] hi_sum;
    logic            hi_cout;

    logic [N_32-1:0] raw;
    logic [N_32-1:0] res;
    logic            ovf;
    logic [2:0]      flags_d;

    logic            out_valid_q;
    logic [N_32-1:0] diff_q;
    logic            bout_q;
    logic [2:0]      flags_q;

    assign s2_ready = ~out_valid_q | OUT_READY;
    assign s1_ready = ~s1_valid | s2_ready;
    assign accept   = IN_VALID & s1_ready;
    assign IN_READY = s1_ready;

    cla_sub_16 u_lo (
        .x    (OPA[N_16-1:0]),
        .y    (OPB[N_16-1:0]),
        .cin  (~BIN),
        .sum  (lo_sum),
        .cout (lo_cout)
    );

    assign s1_d.dlo = lo_sum;
    assign s1_d.clo = lo_cout;
    assign s1_d.ahi = OPA[N_32-1:N_16];
    assign s1_d.bhi = OPB[N_32-1:N_16];

    // Stage 1: capture low result and high operands on accept.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (s1_ready) begin
            s1_valid <= IN_VALID;
            if (accept) begin
                s1_q <= s1_d;
            end
        end
    end

    cla_sub_16 u_hi (
        .x    (s1_q.ahi),
        .y    (s1_q.bhi),
        .cin  (s1_q.clo),
        .sum  (hi_sum),
        .cout (hi_cout)
    );

    assign raw = {hi_sum, s1_q.dlo};
    assign ovf = (s1_q.ahi[N_16-1] ^ s1_q.bhi[N_16-1])
               & (raw[N_32-1] ^ s1_q.ahi[N_16-1]);

`ifdef CLA_SUB_SAT_EN
    // Clamp to the signed limit on the minuend's side when overflowing.
    always_comb begin
        res = raw;
        if (ovf) begin
            res = s1_q.ahi[N_16-1] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    assign res = raw;
`endif

    // Flags are derived from the value actually presented on DIFF.
    always_comb begin
        flags_d         = '0;
        flags_d[FLAG_N] = res[N_32-1];
        flags_d[FLAG_Z] = (res == '0);
        flags_d[FLAG_V] = ovf;
    end

    // Stage 2: output register, held while the consumer stalls.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            flags_q     <= '0;
        end else if (s2_ready) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                diff_q  <= res;
                bout_q  <= ~hi_cout;
                flags_q <= flags_d;
            end
        end
    end

    assign OUT_VALID = out_valid_q;
    assign DIFF      = diff_q;
    assign BOUT      = bout_q;
    assign FLAGS     = flags_q;

endmodule

// File: tb/tb_cla_sub_pipe_32.sv
// Scoreboard bench for cla_sub_pipe_32: directed, stall, reset, random.
// Honours CLA_SUB_SAT_EN when computing expected results.
module tb_cla_sub_pipe_32;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IN_VALID;
    logic        IN_READY;
    logic [31:0] OPA;
    logic [31:0] OPB;
    logic        BIN;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] DIFF;
    logic        BOUT;
    logic [2:0]  FLAGS;

    typedef struct packed {
        logic [31:0] d;
        logic        bo;
        logic [2:0]  f;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    cla_sub_pipe_32 dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .OPA       (OPA),
        .OPB       (OPB),
        .BIN       (BIN),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .DIFF      (DIFF),
        .BOUT      (BOUT),
        .FLAGS     (FLAGS)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc++;

    // Output side of the scoreboard: pop on every handshake.
    always @(negedge CLK) begin : mon
        exp_t e;
        if (!RST && OUT_VALID && OUT_READY) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output diff=%h bout=%b flags=%b",
                         DIFF, BOUT, FLAGS);
            end else begin
                e = sb.pop_front();
                if ({DIFF, BOUT, FLAGS} !== e) begin
                    n_err++;
                    $display("FAIL result got d=%h bo=%b f=%b exp d=%h bo=%b f=%b",
                             DIFF, BOUT, FLAGS, e.d, e.bo, e.f);
                end
            end
        end
    end

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic bi);
        logic [32:0] f;
        logic [31:0] d;
        logic        v;
        exp_t        e;
        f = {1'b0, a} - {1'b0, b} - {32'd0, bi};
        d = f[31:0];
        v = (a[31] ^ b[31]) & (d[31] ^ a[31]);
`ifdef CLA_SUB_SAT_EN
        if (v) d = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        e.d  = d;
        e.bo = f[32];
        e.f  = {d[31], (d == 32'd0), v};
        return e;
    endfunction

    // Present one operand set; called at posedge+1, returns at posedge+1.
    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic bi, input exp_t e);
        int t;
        bit ok;
        IN_VALID = 1'b1;
        OPA = a;
        OPB = b;
        BIN = bi;
        t  = 0;
        ok = 0;
        while (!ok && t < 50) begin
            @(negedge CLK);
            ok = IN_READY;
            if (ok) sb.push_back(e);
            @(posedge CLK);
            #1;
            t++;
        end
        IN_VALID = 1'b0;
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout in_ready=%b required 1", IN_READY);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(posedge CLK);
            #1;
            t++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout pending=%0d required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        RST       = 1'b1;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b0;
        OPA = '0;
        OPB = '0;
        BIN = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        n_vec++;
        if (OUT_VALID !== 1'b0) begin
            n_err++;
            $display("FAIL reset_out_valid got %b required 0", OUT_VALID);
        end
        n_vec++;
        if ({DIFF, BOUT, FLAGS} !== 36'd0) begin
            n_err++;
            $display("FAIL reset_data got d=%h bo=%b f=%b required 0",
                     DIFF, BOUT, FLAGS);
        end
        RST = 1'b0;
        #1;
        n_vec++;
        if (IN_READY !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready got %b required 1", IN_READY);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_latency();
        OUT_READY = 1'b1;
        send(32'd5, 32'd3, 1'b0, exp_t'{32'h0000_0002, 1'b0, 3'b000});
        n_vec++;
        if (OUT_VALID !== 1'b0) begin
            n_err++;
            $display("FAIL latency_early got %b required 0", OUT_VALID);
        end
        @(posedge CLK);
        #1;
        n_vec++;
        if (OUT_VALID !== 1'b1) begin
            n_err++;
            $display("FAIL latency_two got %b required 1", OUT_VALID);
        end
        drain();
    endtask

    task automatic test_boundary();
        OUT_READY = 1'b1;
        send(32'h0001_0000, 32'h0000_0001, 1'b0,
             exp_t'{32'h0000_FFFF, 1'b0, 3'b000});
        send(32'h0000_0000, 32'h0000_0001, 1'b0,
             exp_t'{32'hFFFF_FFFF, 1'b1, 3'b100});
        send(32'h0000_0007, 32'h0000_0007, 1'b0,
             exp_t'{32'h0000_0000, 1'b0, 3'b010});
`ifdef CLA_SUB_SAT_EN
        send(32'h8000_0000, 32'h0000_0001, 1'b0,
             exp_t'{32'h8000_0000, 1'b0, 3'b101});
`else
        send(32'h8000_0000, 32'h0000_0001, 1'b0,
             exp_t'{32'h7FFF_FFFF, 1'b0, 3'b001});
`endif
        send(32'h0000_0009, 32'h0000_0004, 1'b1,
             exp_t'{32'h0000_0004, 1'b0, 3'b000});
        drain();
    endtask

    task automatic test_stall();
        exp_t e1;
        e1 = model(32'd100, 32'd1, 1'b0);
        OUT_READY = 1'b0;
        send(32'd100, 32'd1, 1'b0, e1);
        send(32'd200, 32'd2, 1'b0, model(32'd200, 32'd2, 1'b0));
        IN_VALID = 1'b1;
        OPA = 32'd300;
        OPB = 32'd3;
        BIN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            n_vec++;
            if (IN_READY !== 1'b0) begin
                n_err++;
                $display("FAIL stall_in_ready got %b required 0", IN_READY);
            end
            n_vec++;
            if (OUT_VALID !== 1'b1 || DIFF !== e1.d) begin
                n_err++;
                $display("FAIL stall_hold got v=%b d=%h required v=1 d=%h",
                         OUT_VALID, DIFF, e1.d);
            end
            @(posedge CLK);
            #1;
        end
        OUT_READY = 1'b1;
        send(32'd300, 32'd3, 1'b0, model(32'd300, 32'd3, 1'b0));
        drain();
    endtask

    task automatic test_back_to_back();
        int          c0;
        logic [31:0] a;
        logic [31:0] b;
        logic        bi;
        OUT_READY = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 8; i++) begin
            a  = $urandom;
            b  = $urandom;
            bi = 1'($urandom_range(0, 1));
            send(a, b, bi, model(a, b, bi));
        end
        n_vec++;
        if (cyc - c0 != 8) begin
            n_err++;
            $display("FAIL throughput got %0d cycles required 8", cyc - c0);
        end
        fork
            begin
                logic [31:0] ra;
                logic [31:0] rb;
                logic        rbi;
                for (int i = 0; i < 24; i++) begin
                    ra  = (i % 4 == 0) ? 32'h8000_0000 : $urandom;
                    rb  = (i % 5 == 0) ? 32'h7FFF_FFFF : $urandom;
                    rbi = 1'($urandom_range(0, 1));
                    send(ra, rb, rbi, model(ra, rb, rbi));
                end
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    @(posedge CLK);
                    #1;
                    OUT_READY = 1'($urandom_range(0, 1));
                end
                OUT_READY = 1'b1;
            end
        join
        drain();
    endtask

    task automatic test_reset_midflight();
        OUT_READY = 1'b0;
        send(32'd50, 32'd8, 1'b0, model(32'd50, 32'd8, 1'b0));
        send(32'd60, 32'd9, 1'b0, model(32'd60, 32'd9, 1'b0));
        @(negedge CLK);
        n_vec++;
        if (OUT_VALID !== 1'b1 || IN_READY !== 1'b0) begin
            n_err++;
            $display("FAIL full_before_reset got v=%b r=%b required v=1 r=0",
                     OUT_VALID, IN_READY);
        end
        RST = 1'b1;
        #1;
        n_vec++;
        if (OUT_VALID !== 1'b0 || DIFF !== 32'd0) begin
            n_err++;
            $display("FAIL async_reset got v=%b d=%h required v=0 d=0",
                     OUT_VALID, DIFF);
        end
        sb.delete();
        @(posedge CLK);
        #1;
        RST = 1'b0;
        OUT_READY = 1'b1;
        #1;
        n_vec++;
        if (IN_READY !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset_in_ready got %b required 1", IN_READY);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            n_vec++;
            if (OUT_VALID !== 1'b0) begin
                n_err++;
                $display("FAIL stale_output got v=%b required 0", OUT_VALID);
            end
        end
        @(posedge CLK);
        #1;
        send(32'd9, 32'd4, 1'b1, exp_t'{32'h0000_0004, 1'b0, 3'b000});
        drain();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_boundary();
        test_stall();
        test_back_to_back();
        test_reset_midflight();
        repeat (3) @(posedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout reached without finishing");
        $fatal(1);
    end

endmodule
